hh_gate_scheduler: RTL and testbench

Sequencer that time-multiplexes one shared Hodgkin-Huxley gate-update datapath (alpha/beta rate evaluation plus Euler step) across the three gating variables m, h and n of a neuron. Once per simulation timestep it accepts a membrane voltage, issues one update request per gate, and collects and clamps the results. It then publishes all three gates atomically to the membrane-current stage. All arithmetic is fixed-point; the block is synthesizable.

---
 rtl/hh_gate_scheduler_pkg.sv | 28 ++
 rtl/hh_gate_scheduler.sv | 172 +++++++++++++++++
 tb/tb_hh_gate_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hh_gate_scheduler_pkg.sv
// Shared definitions for the Hodgkin-Huxley gate pipeline: Q-format widths,
// gate constants, gate-select encoding and scheduler state encoding.
package hh_pkg;

    // Gate words are unsigned Q1.15; the gate-update unit reuses these widths.
    localparam int Q_W    = 16;
    localparam int Q_FRAC = 15;

    // 1.0 in Q1.15 and the resting values of the three gates.
    localparam logic [Q_W-1:0] GATE_ONE = Q_W'(1) << Q_FRAC;
    localparam logic [Q_W-1:0] M_REST   = 16'h06C9;  // 0.053
    localparam logic [Q_W-1:0] H_REST   = 16'h4C4A;  // 0.596
    localparam logic [Q_W-1:0] N_REST   = 16'h28B4;  // 0.318

    // Gate-select encoding shared with the gate-update unit.
    localparam logic [1:0] GATE_M = 2'd0;
    localparam logic [1:0] GATE_H = 2'd1;
    localparam logic [1:0] GATE_N = 2'd2;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/hh_gate_scheduler.sv
// Time-multiplexes one shared gate-update datapath over the m, h and n gates.
// A step latches the voltage, issues one request per gate, clamps each result
// into a shadow register, then publishes all three gates together in DONE.
//
// Handshakes: a request transfers on a clock edge where gu_req_valid and
// gu_req_ready are both high; while gu_req_valid is high, gu_sel, gu_x and
// gu_v are held stable. A step is accepted on an edge where step_valid and
// step_ready are both high. gu_resp_valid has no ready; it is consumed only
// in WAIT and ignored in every other state.
module hh_gate_scheduler
    import hh_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_valid,
    output logic             step_ready,
    input  logic [WIDTH-1:0] v_in,
    output logic             gu_req_valid,
    input  logic             gu_req_ready,
    output logic [1:0]       gu_sel,
    output logic [WIDTH-1:0] gu_v,
    output logic [WIDTH-1:0] gu_x,
    input  logic             gu_resp_valid,
    input  logic [WIDTH-1:0] gu_resp_x,
    output logic [WIDTH-1:0] m_out,
    output logic [WIDTH-1:0] h_out,
    output logic [WIDTH-1:0] n_out,
    output logic             step_done,
    output logic             timeout_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(GATE_ONE);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    sched_state_e     state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] shadow_d [3];
    logic [WIDTH-1:0] out_q [3];
    logic [WIDTH-1:0] out_d [3];
    logic             timeout_q, timeout_d;

    logic [WIDTH-1:0] resp_clamped;
    logic [WIDTH-1:0] sel_x;
    logic             gate_finished;

    // Clamp the raw response into [0, 1.0]. Euler-step results are read as
    // lying in [-0.5, 1.5): top bits 11 is an undershoot below zero, while
    // 0x8001..0xBFFF is an overshoot above 1.0.
    always_comb begin
        resp_clamped = gu_resp_x;
        if (gu_resp_x[WIDTH-1 -: 2] == 2'b11) begin
            resp_clamped = '0;
        end else if (gu_resp_x > ONE_W) begin
            resp_clamped = ONE_W;
        end
    end

    // Select the shadow value of the gate currently being serviced.
    always_comb begin
        sel_x = shadow_q[0];
        case (idx_q)
            GATE_H:  sel_x = shadow_q[1];
            GATE_N:  sel_x = shadow_q[2];
            default: sel_x = shadow_q[0];
        endcase
    end

    // Next-state logic: step sequencing, shadow updates, timeout and publish.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_cnt_d    = wait_cnt_q;
        v_d           = v_q;
        shadow_d      = shadow_q;
        out_d         = out_q;
        timeout_d     = timeout_q;
        gate_finished = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (step_valid) begin
                    v_d     = v_in;
                    idx_d   = GATE_M;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (gu_req_ready) begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                // A response in the last allowed cycle still wins over timeout.
                if (gu_resp_valid) begin
                    for (int i = 0; i < 3; i++) begin
                        if (idx_q == 2'(i)) begin
                            shadow_d[i] = resp_clamped;
                        end
                    end
                    gate_finished = 1'b1;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    timeout_d     = 1'b1;
                    gate_finished = 1'b1;
                end
                if (gate_finished) begin
                    if (idx_q == GATE_N) begin
                        // Outputs load on entry to DONE so all three gates
                        // come from the same step.
                        out_d   = shadow_d;
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset to rest values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= GATE_M;
            wait_cnt_q  <= '0;
            v_q         <= '0;
            shadow_q[0] <= WIDTH'(M_REST);
            shadow_q[1] <= WIDTH'(H_REST);
            shadow_q[2] <= WIDTH'(N_REST);
            out_q[0]    <= WIDTH'(M_REST);
            out_q[1]    <= WIDTH'(H_REST);
            out_q[2]    <= WIDTH'(N_REST);
            timeout_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wait_cnt_q <= wait_cnt_d;
            v_q        <= v_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
            timeout_q  <= timeout_d;
        end
    end

    // All outputs are decoded from registers only.
    assign step_ready   = (state_q == ST_IDLE);
    assign gu_req_valid = (state_q == ST_ISSUE);
    assign step_done    = (state_q == ST_DONE);
    assign gu_sel       = idx_q;
    assign gu_v         = v_q;
    assign gu_x         = sel_x;
    assign m_out        = out_q[0];
    assign h_out        = out_q[1];
    assign n_out        = out_q[2];
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_hh_gate_scheduler.sv
// Self-checking bench for hh_gate_scheduler: a reference model predicts the
// request stream and published gates; a scoreboard queue holds expectations.
module tb_hh_gate_scheduler;

    localparam int W        = 16;
    localparam int MAX_WAIT = 15;

    logic         clk;
    logic         reset;
    logic         step_valid;
    logic         step_ready;
    logic [W-1:0] v_in;
    logic         gu_req_valid;
    logic         gu_req_ready;
    logic [1:0]   gu_sel;
    logic [W-1:0] gu_v;
    logic [W-1:0] gu_x;
    logic         gu_resp_valid;
    logic [W-1:0] gu_resp_x;
    logic [W-1:0] m_out;
    logic [W-1:0] h_out;
    logic [W-1:0] n_out;
    logic         step_done;
    logic         timeout_err;

    hh_gate_scheduler #(.WIDTH(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset),
        .step_valid(step_valid), .step_ready(step_ready), .v_in(v_in),
        .gu_req_valid(gu_req_valid), .gu_req_ready(gu_req_ready),
        .gu_sel(gu_sel), .gu_v(gu_v), .gu_x(gu_x),
        .gu_resp_valid(gu_resp_valid), .gu_resp_x(gu_resp_x),
        .m_out(m_out), .h_out(h_out), .n_out(n_out),
        .step_done(step_done), .timeout_err(timeout_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    logic [47:0] exp_q [$];     // expected {m,h,n} per published step
    logic [33:0] req_q [$];     // expected {sel, x, v} per gate request
    logic [W-1:0] mdl_sh [3];
    bit           mdl_to;
    int           n_checks = 0;
    int           n_pass   = 0;

    // per-step stimulus configuration
    int           hold_cfg [3];  // cycles gu_req_ready stays low per request
    int           lat_cfg [3];   // WAIT cycle carrying the response; 0 = none
    bit           ovr_en [3];
    logic [W-1:0] ovr_val [3];
    bit           late_cfg;      // stray response during the n ISSUE

    function automatic logic [W-1:0] clamp_model(input logic [W-1:0] r);
        if (r >= 16'hC000) return 16'h0000;
        if (r > 16'h8000) return 16'h8000;
        return r;
    endfunction

    task automatic model_reset();
        mdl_sh[0] = 16'h06C9;
        mdl_sh[1] = 16'h4C4A;
        mdl_sh[2] = 16'h28B4;
        mdl_to    = 1'b0;
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 3; i++) begin
            hold_cfg[i] = 0;
            lat_cfg[i]  = 1;
            ovr_en[i]   = 1'b0;
            ovr_val[i]  = '0;
        end
        late_cfg = 1'b0;
    endtask

    // ---------------- driver: one full step ----------------
    task automatic run_step(input logic [W-1:0] v, input string name);
        int          n;
        int          exp_n;
        int          g;
        int          hold;
        int          wcnt;
        int          exp_w;
        bit          seen;
        bit          in_wait;
        bit          done_seen;
        bit          late_pending;
        logic [33:0] cur_req;
        logic [47:0] exp_o;
        logic [W-1:0] r;
        logic [1:0]  sel;

        // Predict the request stream, final outputs and completion cycle.
        exp_n = 7;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            req_q.push_back({sel, mdl_sh[i], v});
            exp_n += hold_cfg[i];
            if (late_cfg && i == 2) exp_n += 1;
            if (lat_cfg[i] == 0) begin
                exp_n += MAX_WAIT - 1;
                mdl_to = 1'b1;
            end else begin
                r = ovr_en[i] ? ovr_val[i] : mdl_sh[i] + 16'd1;
                mdl_sh[i] = clamp_model(r);
                exp_n += lat_cfg[i] - 1;
            end
        end
        exp_q.push_back({mdl_sh[0], mdl_sh[1], mdl_sh[2]});

        @(negedge clk);
        step_valid = 1'b1;
        v_in       = v;
        @(negedge clk);
        step_valid = 1'b0;
        v_in       = ~v;

        n = 1; g = -1; hold = 0; wcnt = 0; seen = 1'b0; in_wait = 1'b0;
        done_seen = 1'b0; late_pending = 1'b0; cur_req = '0;
        while (!done_seen && n <= 300) begin
            if (in_wait && (gu_req_valid || step_done)) begin
                exp_w = (lat_cfg[g] == 0) ? MAX_WAIT : lat_cfg[g];
                n_checks++;
                if (wcnt !== exp_w)
                    $display("FAIL %s wait_cycles gate %0d: got %0d expected %0d", name, g, wcnt, exp_w);
                else n_pass++;
                in_wait = 1'b0;
            end
            if (step_done) begin
                done_seen = 1'b1;
                gu_req_ready  = 1'b0;
                gu_resp_valid = 1'b0;
                n_checks++;
                if (n !== exp_n)
                    $display("FAIL %s done_cycle: got T+%0d expected T+%0d", name, n, exp_n);
                else n_pass++;
                exp_o = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
                n_checks++;
                if ({m_out, h_out, n_out} !== exp_o)
                    $display("FAIL %s outputs: got %h/%h/%h expected %h/%h/%h", name,
                             m_out, h_out, n_out, exp_o[47:32], exp_o[31:16], exp_o[15:0]);
                else n_pass++;
                n_checks++;
                if (timeout_err !== mdl_to)
                    $display("FAIL %s timeout_err: got %b expected %b", name, timeout_err, mdl_to);
                else n_pass++;
            end else if (gu_req_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    g++;
                    cur_req = (req_q.size() > 0) ? req_q.pop_front() : 34'hx;
                    hold = (g < 3) ? hold_cfg[g] : 0;
                    late_pending = late_cfg && (g == 2);
                end
                n_checks++;
                if ({gu_sel, gu_x, gu_v} !== cur_req)
                    $display("FAIL %s request: got sel=%0d x=%h v=%h expected sel=%0d x=%h v=%h",
                             name, gu_sel, gu_x, gu_v, cur_req[33:32], cur_req[31:16], cur_req[15:0]);
                else n_pass++;
                if (late_pending) begin
                    gu_req_ready  = 1'b0;
                    gu_resp_valid = 1'b1;
                    gu_resp_x     = 16'h0000;
                    late_pending  = 1'b0;
                end else if (hold > 0) begin
                    gu_req_ready  = 1'b0;
                    gu_resp_valid = 1'b0;
                    hold--;
                end else begin
                    gu_req_ready  = 1'b1;
                    gu_resp_valid = 1'b0;
                    in_wait = 1'b1;
                    wcnt    = 0;
                    seen    = 1'b0;
                end
            end else if (in_wait) begin
                wcnt++;
                gu_req_ready = 1'b0;
                if (lat_cfg[g] != 0 && wcnt == lat_cfg[g]) begin
                    gu_resp_valid = 1'b1;
                    gu_resp_x = ovr_en[g] ? ovr_val[g] : cur_req[31:16] + 16'd1;
                end else begin
                    gu_resp_valid = 1'b0;
                end
            end else begin
                gu_req_ready  = 1'b0;
                gu_resp_valid = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        gu_req_ready  = 1'b0;
        gu_resp_valid = 1'b0;

        n_checks++;
        if (!done_seen) begin
            $display("FAIL %s step_done_missing: got none expected pulse within %0d cycles", name, 300);
            exp_q.delete();
            req_q.delete();
        end else n_pass++;
        // One cycle after DONE: pulse gone and ready for the next step.
        n_checks++;
        if (step_done !== 1'b0 || step_ready !== 1'b1)
            $display("FAIL %s after_done: got done=%b ready=%b expected done=0 ready=1", name, step_done, step_ready);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({m_out, h_out, n_out} !== {16'h06C9, 16'h4C4A, 16'h28B4})
            $display("FAIL reset_outputs: got %h/%h/%h expected 06c9/4c4a/28b4", m_out, h_out, n_out);
        else n_pass++;
        n_checks++;
        if ({step_ready, gu_req_valid, step_done, timeout_err} !== 4'b1000)
            $display("FAIL reset_flags: got ready=%b req=%b done=%b to=%b expected 1/0/0/0",
                     step_ready, gu_req_valid, step_done, timeout_err);
        else n_pass++;
        n_checks++;
        if ({gu_sel, gu_v, gu_x} !== {2'd0, 16'h0000, 16'h06C9})
            $display("FAIL reset_request_fields: got sel=%0d v=%h x=%h expected 0/0000/06c9", gu_sel, gu_v, gu_x);
        else n_pass++;
    endtask

    task automatic test_basic();
        clear_cfg();
        run_step(16'hBF00, "basic");
    endtask

    task automatic test_backpressure();
        clear_cfg();
        hold_cfg[1] = 3;
        run_step(16'hC400, "backpressure");
    endtask

    task automatic test_clamp();
        clear_cfg();
        ovr_en[0] = 1'b1; ovr_val[0] = 16'hFFF0;
        ovr_en[2] = 1'b1; ovr_val[2] = 16'h9000;
        run_step(16'h0A00, "clamp");
    endtask

    task automatic test_max_latency();
        clear_cfg();
        for (int i = 0; i < 3; i++) lat_cfg[i] = MAX_WAIT;
        ovr_en[0] = 1'b1; ovr_val[0] = 16'h8000;
        run_step(16'hB000, "max_latency");
    endtask

    task automatic test_timeout();
        clear_cfg();
        lat_cfg[1] = 0;
        late_cfg   = 1'b1;
        run_step(16'hBF00, "timeout");
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 4; s++) begin
            clear_cfg();
            for (int i = 0; i < 3; i++) begin
                hold_cfg[i] = $urandom_range(0, 2);
                lat_cfg[i]  = $urandom_range(1, MAX_WAIT);
                ovr_en[i]   = ($urandom_range(0, 3) == 0);
                ovr_val[i]  = 16'($urandom_range(0, 16'hFFFF));
            end
            run_step(16'($urandom_range(0, 16'hFFFF)), "back_to_back");
        end
    endtask

    task automatic test_reset_mid_step();
        bit         fired;
        bit         acc;
        bit         done_any;
        logic [1:0] last_sel;
        @(negedge clk);
        step_valid = 1'b1;
        v_in       = 16'h1000;
        @(negedge clk);
        step_valid = 1'b0;
        fired = 1'b0; acc = 1'b0; last_sel = 2'd0;
        for (int n = 0; n < 100 && !fired; n++) begin
            if (acc) begin
                gu_req_ready = 1'b0;
                if (last_sel == 2'd2) begin
                    reset = 1'b1;
                    fired = 1'b1;
                end else begin
                    gu_resp_valid = 1'b1;
                    gu_resp_x     = 16'h1234;
                end
                acc = 1'b0;
            end else begin
                gu_resp_valid = 1'b0;
                gu_req_ready  = gu_req_valid;
                if (gu_req_valid) begin
                    last_sel = gu_sel;
                    acc      = 1'b1;
                end
            end
            @(negedge clk);
        end
        gu_req_ready  = 1'b0;
        gu_resp_valid = 1'b0;
        model_reset();
        n_checks++;
        if (!fired) $display("FAIL reset_mid_reach_wait_n: got no n request expected one");
        else n_pass++;
        n_checks++;
        if ({step_ready, gu_req_valid, step_done, timeout_err} !== 4'b1000)
            $display("FAIL reset_mid_flags: got ready=%b req=%b done=%b to=%b expected 1/0/0/0",
                     step_ready, gu_req_valid, step_done, timeout_err);
        else n_pass++;
        n_checks++;
        if ({m_out, h_out, n_out} !== {16'h06C9, 16'h4C4A, 16'h28B4})
            $display("FAIL reset_mid_outputs: got %h/%h/%h expected 06c9/4c4a/28b4", m_out, h_out, n_out);
        else n_pass++;
        reset = 1'b0;
        done_any = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (step_done) done_any = 1'b1;
        end
        n_checks++;
        if (done_any) $display("FAIL reset_mid_no_done: got step_done pulse expected none");
        else n_pass++;
        // Shadows must also be back at rest: a fresh step yields rest+1.
        clear_cfg();
        run_step(16'hBF00, "after_reset");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset         = 1'b1;
        step_valid    = 1'b0;
        v_in          = '0;
        gu_req_ready  = 1'b0;
        gu_resp_valid = 1'b0;
        gu_resp_x     = '0;
        model_reset();
        clear_cfg();

        test_reset();
        test_basic();
        test_backpressure();
        test_clamp();
        test_max_latency();
        test_back_to_back();
        test_timeout();
        test_reset_mid_step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
